rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
Sequencing controller for the RX shift sampler. It gates the RX PCB signal into the sampler and detects the end of each capture. It latches the captured sample vector, majority-votes it into frame bits, checks framing, and hands the data byte downstream on a valid/ready handshake. It also keeps saturating frame and error counters for the bring-up registers.

Parameters:
SAMPLES, 80, width of the sampler's sample vector
SPB, 8, samples per frame bit; NBITS = SAMPLES/SPB = 10
TIMEOUT, 100, max cycles the sampler's busy flag may stay high before abort
CNT_W, 16, width of the status counters

Ports:
clk  in  1  40 kHz sample clock, shared with the sampler
rst_n  in  1  asynchronous active-low reset
enable  in  1  arms reception; 0 returns the block to IDLE at the next frame boundary
rx_signal  in  1  raw demodulated signal from the RX PCB
smp_signal  out  1  gated signal driven into the sampler
smp_busy  in  1  sampler's sample flag
smp_vec  in  SAMPLES  sampler's sample vector; chronologically first sample is at index SAMPLES-1
data  out  8  decoded byte
data_valid  out  1  data holds a good frame
data_ready  in  1  downstream accepts data
frame_err  out  1  one-cycle pulse on framing error or timeout
overrun  out  1  sticky; set when a frame is dropped because data_valid was still pending; cleared by reset
frame_cnt  out  CNT_W  good frames delivered, saturating
err_cnt  out  CNT_W  framing errors, timeouts and overruns, saturating

Behaviour:
- One clock; reset is asynchronous and active-low. On reset: state=IDLE, smp_signal=0, data=0, data_valid=0, frame_err=0, overrun=0, counters=0.
- smp_signal = rx_signal when state is IDLE or CAPTURE and enable=1; otherwise 0 (combinational gate).
- IDLE: go to CAPTURE on the first cycle smp_busy=1.
- CAPTURE:
  - Count cycles while smp_busy=1.
  - On smp_busy 1->0 (registered edge detect), latch smp_vec into the internal shadow register and go to DECODE.
  - If the count reaches TIMEOUT: pulse frame_err, increment err_cnt, go to IDLE.
- DECODE: NBITS cycles, one bit per cycle.
  - Frame bit i uses samples [SAMPLES-1-i*SPB -: SPB].
  - Bit = 1 iff popcount > SPB/2; a tie decodes as 0.
  - Bits shift into a 10-bit frame register.
  - Frame format: bit0 = start (must be 1), bits1..8 = data LSB first, bit9 = stop (must be 0).
- CHECK (1 cycle):
  - Bad start or stop: pulse frame_err, increment err_cnt, go to IDLE.
  - Good frame with data_valid=0: load data, set data_valid, increment frame_cnt, go to IDLE.
  - Good frame with data_valid=1: drop the frame, set overrun, increment err_cnt, keep the old data, go to IDLE.
- Latency: data_valid rises NBITS+2 cycles after the cycle smp_busy is sampled low.
- Handshake: data_valid stays high and data stays stable until a cycle with data_valid & data_ready, after which data_valid=0 the next cycle. Handshake runs independently of the FSM, so a new capture may proceed while data_valid is pending.
- enable=0 mid-frame: the current capture/decode completes and the result is reported normally. The FSM then waits in IDLE with smp_signal=0.
- Reset mid-operation: all state is discarded immediately; no partial frame is delivered.
- Counters saturate at all-ones and never wrap.
- CHECK completing a good frame in the same cycle as a handshake accept: the accept wins first, so the new frame loads and data_valid stays 1.

Decomposition:
- Package rx_pkg holds:
  - State enum IDLE/CAPTURE/DECODE/CHECK
  - Frame field constants: START_VAL=1, STOP_VAL=0, DATA_LSB=1, DATA_W=8
  - Default SAMPLES/SPB
- One sub-module: rx_bit_vote (combinational popcount of SPB bits -> bit value plus tie flag), instantiated once and indexed by the DECODE bit counter.

Test Plan:
- Byte 0xA5 framed (start=1, LSB-first data, stop=0), each bit as 8 identical samples, data_ready=1 -> data=0xA5, data_valid high exactly 12 cycles after busy falls, frame_cnt=1, err_cnt=0.
- Same frame with 3 of 8 samples flipped in every bit -> majority still yields data=0xA5. With exactly 4 of 8 flipped in data bit 0 -> tie decodes as 0, data=0xA4.
- Stop bit sampled as all-ones -> frame_err pulses once, data_valid stays 0, err_cnt=1.
- smp_busy held high for 100 cycles -> timeout: frame_err pulses, state returns to IDLE, err_cnt increments, smp_signal re-enabled.
- Two good frames 0x11 then 0x22 with data_ready=0 -> data stays 0x11, overrun=1, err_cnt=1. Raise data_ready -> data_valid drops the next cycle.
- Assert rst_n=0 during DECODE -> all outputs return to reset values asynchronously, and no data_valid appears after release.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and frame-field constants for the RX frame controller.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DECODE  = 2'd2,
    CHECK   = 2'd3
  } rx_state_e;

  localparam logic        START_VAL   = 1'b1;
  localparam logic        STOP_VAL    = 1'b0;
  localparam int unsigned DATA_LSB    = 1;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEF_SAMPLES = 80;
  localparam int unsigned DEF_SPB     = 8;

endpackage

// File: rtl/rx_bit_vote.sv
// Majority vote over one frame bit's samples; a tie resolves to 0.
module rx_bit_vote #(
  parameter int unsigned SPB = 8
) (
  input  logic [SPB-1:0] samples,
  output logic           bit_val,
  output logic           tie
);

  localparam int unsigned CW = $clog2(SPB + 1);
  localparam logic [CW-1:0] HALF = CW'(SPB / 2);

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < SPB; i++) begin
      ones = ones + CW'(samples[i]);
    end
    bit_val = (ones > HALF);
    tie     = (ones == HALF);
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// RX sequencing controller: gates the sampler, captures and majority-decodes
// a frame, checks framing and delivers the byte on a valid/ready handshake.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int unsigned SAMPLES = DEF_SAMPLES,
  parameter int unsigned SPB     = DEF_SPB,
  parameter int unsigned TIMEOUT = 100,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               rx_signal,
  output logic               smp_signal,
  input  logic               smp_busy,
  input  logic [SAMPLES-1:0] smp_vec,
  output logic [DATA_W-1:0]  data,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int unsigned NBITS = SAMPLES / SPB;
  localparam int unsigned BIT_W = $clog2(NBITS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = $clog2(SAMPLES);

  rx_state_e          state_q, state_d;
  logic               busy_q, busy_d;
  logic               busy_prev_q, busy_prev_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [SAMPLES-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dv_q, dv_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   ecnt_q, ecnt_d;

  logic               busy_fall;
  logic               fcnt_inc, ecnt_inc;
  logic [IDX_W-1:0]   vote_base;
  logic [SPB-1:0]     vote_grp;
  logic               vote_val, vote_tie, vote_bit;

  always_comb begin
    vote_base = IDX_W'(SAMPLES - 1 - SPB * bit_idx_q);
    vote_grp  = shadow_q[vote_base -: SPB];
  end

  rx_bit_vote #(.SPB(SPB)) u_vote (
    .samples (vote_grp),
    .bit_val (vote_val),
    .tie     (vote_tie)
  );

  assign vote_bit   = vote_val & ~vote_tie;
  assign busy_fall  = busy_prev_q & ~busy_q;
  assign smp_signal = rst_n & enable & rx_signal &
                      ((state_q == IDLE) || (state_q == CAPTURE));

  always_comb begin
    state_d     = state_q;
    busy_d      = smp_busy;
    busy_prev_d = busy_q;
    to_cnt_d    = to_cnt_q;
    bit_idx_d   = bit_idx_q;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    data_d      = data_q;
    dv_d        = dv_q;
    ferr_d      = 1'b0;
    ovr_d       = ovr_q;
    fcnt_d      = fcnt_q;
    ecnt_d      = ecnt_q;
    fcnt_inc    = 1'b0;
    ecnt_inc    = 1'b0;

    // Accept is resolved before CHECK so a same-cycle good frame can reload.
    if (dv_q && data_ready) dv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && smp_busy) begin
          state_d  = CAPTURE;
          to_cnt_d = TO_W'(1);
        end
      end
      CAPTURE: begin
        if (busy_fall) begin
          shadow_d  = smp_vec;
          bit_idx_d = '0;
          state_d   = DECODE;
        end else if (smp_busy) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            ferr_d   = 1'b1;
            ecnt_inc = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DECODE: begin
        frame_d   = {vote_bit, frame_q[NBITS-1:1]};
        bit_idx_d = bit_idx_q + BIT_W'(1);
        if (bit_idx_q == BIT_W'(NBITS - 1)) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if ((frame_q[0] != START_VAL) || (frame_q[NBITS-1] != STOP_VAL)) begin
          ferr_d   = 1'b1;
          ecnt_inc = 1'b1;
        end else if (!dv_q || data_ready) begin
          data_d   = frame_q[DATA_LSB +: DATA_W];
          dv_d     = 1'b1;
          fcnt_inc = 1'b1;
        end else begin
          ovr_d    = 1'b1;
          ecnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fcnt_inc && (fcnt_q != '1)) fcnt_d = fcnt_q + CNT_W'(1);
    if (ecnt_inc && (ecnt_q != '1)) ecnt_d = ecnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      busy_prev_q <= 1'b0;
      to_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shadow_q    <= '0;
      frame_q     <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      fcnt_q      <= '0;
      ecnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      busy_prev_q <= busy_prev_d;
      to_cnt_q    <= to_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      fcnt_q      <= fcnt_d;
      ecnt_q      <= ecnt_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign frame_cnt  = fcnt_q;
  assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a byte scoreboard and immediate assertions.
module tb_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        rx_signal;
  logic        smp_signal;
  logic        smp_busy;
  logic [79:0] smp_vec;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        frame_err;
  logic        overrun;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  rx_frame_ctrl #(.SAMPLES(80), .SPB(8), .TIMEOUT(100), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx_signal  (rx_signal),
    .smp_signal (smp_signal),
    .smp_busy   (smp_busy),
    .smp_vec    (smp_vec),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] build_vec(input logic [7:0] d, input logic bad_stop,
                                            input logic flip3, input logic tie0);
    logic [9:0]  fb;
    logic [7:0]  grp;
    logic [79:0] v;
    fb = {bad_stop, d, 1'b1};
    v  = '0;
    for (int i = 0; i < 10; i++) begin
      grp = {8{fb[i]}};
      if (flip3) grp[2:0] = ~grp[2:0];
      if (tie0 && (i == 1)) grp[3:0] = ~grp[3:0];
      v[79 - 8*i -: 8] = grp;
    end
    return v;
  endfunction

  // Returns at the negedge on which smp_busy is driven low.
  task automatic send(input logic [79:0] vec, input int busy_cycles);
    @(negedge clk);
    smp_vec  = vec;
    smp_busy = 1'b1;
    repeat (busy_cycles) @(negedge clk);
    smp_busy = 1'b0;
  endtask

  task automatic wait_dv(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!data_valid && (k < 40));
  endtask

  task automatic watch(input int n, output int ferr_pulses, output int dv_seen);
    ferr_pulses = 0;
    dv_seen     = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_err)  ferr_pulses++;
      if (data_valid) dv_seen++;
    end
  endtask

  int         k;
  int         pulses;
  int         dvs;
  int         to_idx;
  logic [7:0] exp_b;

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    rx_signal  = 1'b1;
    smp_busy   = 1'b0;
    smp_vec    = '0;
    data_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_data", 32'(data), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_fcnt", 32'(frame_cnt), 32'h0);
    check("rst_ecnt", 32'(err_cnt), 32'h0);
    check("rst_smp", 32'(smp_signal), 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    check("gate_disabled", 32'(smp_signal), 32'h0);
    enable = 1'b1;
    #1 check("gate_idle_hi", 32'(smp_signal), 32'h1);
    rx_signal = 1'b0;
    #1 check("gate_idle_lo", 32'(smp_signal), 32'h0);
    rx_signal = 1'b1;

    // Clean 0xA5 frame and its latency from the busy fall.
    sb.push_back(8'hA5);
    send(build_vec(8'hA5, 1'b0, 1'b0, 1'b0), 20);
    wait_dv(k);
    check("latency", 32'(k - 1), 32'd12);
    exp_b = sb.pop_front();
    check("data_a5", 32'(data), 32'(exp_b));
    check("fcnt_1", 32'(frame_cnt), 32'd1);
    check("ecnt_0", 32'(err_cnt), 32'd0);
    @(negedge clk);
    check("dv_drop", 32'(data_valid), 32'h0);
    repeat (4) @(negedge clk);

    // Three flipped samples per bit still vote correctly.
    sb.push_back(8'hA5);
    send(build_vec(8'hA5, 1'b0, 1'b1, 1'b0), 20);
    wait_dv(k);
    check("dv_flip3", 32'(data_valid), 32'h1);
    exp_b = sb.pop_front();
    check("data_flip3", 32'(data), 32'(exp_b));
    repeat (4) @(negedge clk);

    // 4/8 tie on data bit 0 decodes as 0.
    sb.push_back(8'hA4);
    send(build_vec(8'hA5, 1'b0, 1'b0, 1'b1), 20);
    wait_dv(k);
    check("dv_tie", 32'(data_valid), 32'h1);
    exp_b = sb.pop_front();
    check("data_tie", 32'(data), 32'(exp_b));
    check("fcnt_3", 32'(frame_cnt), 32'd3);
    repeat (4) @(negedge clk);

    // Stop bit sampled high.
    send(build_vec(8'h3C, 1'b1, 1'b0, 1'b0), 20);
    watch(20, pulses, dvs);
    check("badstop_pulses", 32'(pulses), 32'd1);
    check("badstop_dv", 32'(dvs), 32'd0);
    check("badstop_ecnt", 32'(err_cnt), 32'd1);
    check("badstop_fcnt", 32'(frame_cnt), 32'd3);

    // Busy stuck high: abort after 100 sampled-high cycles.
    @(negedge clk);
    smp_busy = 1'b1;
    to_idx   = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (frame_err && (to_idx == 0)) begin
        to_idx   = i;
        smp_busy = 1'b0;
      end
    end
    smp_busy = 1'b0;
    check("timeout_cycle", 32'(to_idx), 32'd100);
    check("timeout_ecnt", 32'(err_cnt), 32'd2);
    check("timeout_ferr_clear", 32'(frame_err), 32'h0);
    rx_signal = 1'b1;
    #1 check("timeout_gate_hi", 32'(smp_signal), 32'h1);
    rx_signal = 1'b0;
    #1 check("timeout_gate_lo", 32'(smp_signal), 32'h0);
    rx_signal = 1'b1;

    // Two frames with downstream stalled: second is an overrun.
    data_ready = 1'b0;
    sb.push_back(8'h11);
    send(build_vec(8'h11, 1'b0, 1'b0, 1'b0), 20);
    wait_dv(k);
    check("ovr_first_dv", 32'(data_valid), 32'h1);
    repeat (3) @(negedge clk);
    send(build_vec(8'h22, 1'b0, 1'b0, 1'b0), 20);
    watch(16, pulses, dvs);
    check("ovr_data_kept", 32'(data), 32'(sb[0]));
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_ecnt", 32'(err_cnt), 32'd3);
    check("ovr_fcnt", 32'(frame_cnt), 32'd4);
    check("ovr_dv_pending", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    exp_b = sb.pop_front();
    check("ovr_data_accept", 32'(data), 32'(exp_b));
    @(negedge clk);
    check("ovr_dv_drop", 32'(data_valid), 32'h0);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of DECODE.
    send(build_vec(8'h5A, 1'b0, 1'b0, 1'b0), 20);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_dv", 32'(data_valid), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    check("mid_rst_fcnt", 32'(frame_cnt), 32'h0);
    check("mid_rst_ecnt", 32'(err_cnt), 32'h0);
    check("mid_rst_smp", 32'(smp_signal), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(30, pulses, dvs);
    check("post_rst_dv", 32'(dvs), 32'd0);
    check("post_rst_ferr", 32'(pulses), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
